// File: rtl/alu_issue.sv
// Command FIFO feeding a registered ALU issue stage and a result holding stage.
// Optional feature: define ALU_ISSUE_CNT_EN to add the done_cnt handshake counter.
module alu_issue #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_a,
  input  logic [3:0] in_b,
  input  logic [3:0] in_op,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [3:0] alu_s,
  input  logic [4:0] alu_res,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [4:0] out_res,
  output logic [3:0] out_op,
  output logic       busy
`ifdef ALU_ISSUE_CNT_EN
  ,
  output logic [7:0] done_cnt
`endif
);

  // state  | meaning
  // IDLE   | nothing in flight, waiting for the FIFO to fill
  // ISSUE  | operands on the ALU, result captured on the next edge
  // HOLD   | result presented downstream until out_ready
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HOLD} state_t;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  state_t          state, state_nxt;
  logic [11:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count, count_nxt;
  logic [3:0]      cur_op;
  logic [11:0]     head;
  logic            push, pop, capture, release_res, empty;

  assign empty    = (count == '0);
  assign in_ready = (count < CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign head     = mem[rd_ptr];
  assign busy     = (state != S_IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (!empty) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_HOLD;
      S_HOLD:  if (out_ready) state_nxt = empty ? S_IDLE : S_ISSUE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    pop         = 1'b0;
    capture     = 1'b0;
    release_res = 1'b0;
    case (state)
      S_IDLE:  pop = !empty;
      S_ISSUE: capture = 1'b1;
      S_HOLD: begin
        release_res = out_ready;
        pop         = out_ready && !empty;
      end
      default: ;
    endcase
  end

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_op, in_a, in_b};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
    end
  end

  // Op 1000 has no ALU function; 1111 makes the ALU return zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a  <= '0;
      alu_b  <= '0;
      alu_s  <= 4'b1111;
      cur_op <= '0;
    end else if (pop) begin
      alu_a  <= head[7:4];
      alu_b  <= head[3:0];
      alu_s  <= (head[11:8] == 4'b1000) ? 4'b1111 : head[11:8];
      cur_op <= head[11:8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_res   <= '0;
      out_op    <= '0;
    end else if (capture) begin
      out_valid <= 1'b1;
      out_res   <= alu_res;
      out_op    <= cur_op;
    end else if (release_res) begin
      out_valid <= 1'b0;
    end
  end

`ifdef ALU_ISSUE_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)                         done_cnt <= '0;
    else if (out_valid && out_ready) done_cnt <= done_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: vector table plus FIFO-fill, reset and counter sequences.
module tb_alu_issue;
  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic [3:0] in_a, in_b, in_op, alu_a, alu_b, alu_s, out_op;
  logic [4:0] alu_res, out_res;
`ifdef ALU_ISSUE_CNT_EN
  logic [7:0] done_cnt;
`endif

  always #5 clk = ~clk;

  alu_issue #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_res(alu_res),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_op(out_op), .busy(busy)
`ifdef ALU_ISSUE_CNT_EN
    , .done_cnt(done_cnt)
`endif
  );

  // Reference ALU: 0 add, 1 sub, 2 and, 3 or, 4 xor, anything else 0.
  always_comb begin
    alu_res = 5'd0;
    case (alu_s)
      4'd0: alu_res = {1'b0, alu_a} + {1'b0, alu_b};
      4'd1: alu_res = {1'b0, alu_a} - {1'b0, alu_b};
      4'd2: alu_res = {1'b0, alu_a & alu_b};
      4'd3: alu_res = {1'b0, alu_a | alu_b};
      4'd4: alu_res = {1'b0, alu_a ^ alu_b};
      default: alu_res = 5'd0;
    endcase
  end

  int tests = 0;
  int failed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] a, b, op;
    logic [4:0] res;
    logic [3:0] s;
  } vec_t;

  vec_t vt[7];

  // Sequence driver state: commands sa/sb/sop, k accepted so far, acc = accept on next edge.
  logic [3:0] sa[6], sb[6], sop[6];
  logic [4:0] sexp[6];
  int n_cmd, k;
  logic acc;

  task automatic drive_step();
    if (acc) k++;
    if (k < n_cmd) begin
      in_a = sa[k]; in_b = sb[k]; in_op = sop[k]; in_valid = 1'b1;
    end else begin
      in_valid = 1'b0;
    end
    acc = in_valid && in_ready;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    k = 0; acc = 1'b0;
  endtask

  initial begin
    int n, got, last, stale;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_op = '0; k = 0; n_cmd = 0; acc = 1'b0;

    vt[0] = '{4'd3,  4'd5, 4'b0000, 5'd8,      4'b0000};
    vt[1] = '{4'd2,  4'd3, 4'b0001, 5'b11111,  4'b0001};
    vt[2] = '{4'hF,  4'd1, 4'b0000, 5'b10000,  4'b0000};
    vt[3] = '{4'd7,  4'd7, 4'b1000, 5'd0,      4'b1111};
    vt[4] = '{4'hC,  4'hA, 4'b0010, 5'd8,      4'b0010};
    vt[5] = '{4'hC,  4'hA, 4'b0100, 5'd6,      4'b0100};
    vt[6] = '{4'hC,  4'hA, 4'b0011, 5'd14,     4'b0011};

    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_res", out_res, 0);
    chk("rst_out_op", out_op, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_s", alu_s, 4'b1111);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    rst = 1'b0;

    // Single commands into an idle block, out_ready held high.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      in_a = vt[i].a; in_b = vt[i].b; in_op = vt[i].op; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 8) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("v%0d_latency", i), n, 2);
      chk($sformatf("v%0d_res", i), out_res, vt[i].res);
      chk($sformatf("v%0d_op", i), out_op, vt[i].op);
      chk($sformatf("v%0d_alu_s", i), alu_s, vt[i].s);
      @(negedge clk);
      chk($sformatf("v%0d_valid_clear", i), out_valid, 0);
    end

    // Backpressure: six commands, downstream stalled, then drained in order.
    sa   = '{4'd1, 4'd3, 4'd5, 4'd6, 4'd5, 4'd9};
    sb   = '{4'd2, 4'd3, 4'd1, 4'd3, 4'd3, 4'd9};
    sop  = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd3, 4'd0};
    sexp = '{5'd3, 5'd0, 5'd4, 5'd2, 5'd7, 5'd18};
    n_cmd = 6; k = 0; acc = 1'b0;
    out_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      drive_step();
      @(negedge clk);
    end
    drive_step();
    chk("fill_accepted", k, 5);
    chk("fill_in_ready", in_ready, 0);
    chk("fill_out_valid", out_valid, 1);
    chk("fill_hold_res", out_res, sexp[0]);
    chk("fill_busy", busy, 1);
    out_ready = 1'b1;
    got = 0; last = 0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      if (out_valid) begin
        chk($sformatf("drain%0d_res", got), out_res, sexp[got]);
        chk($sformatf("drain%0d_op", got), out_op, sop[got]);
        if (got > 0) chk($sformatf("drain%0d_gap", got), c - last, 2);
        last = c;
        got++;
      end
      drive_step();
      @(negedge clk);
    end
    chk("drain_count", got, 6);
    @(negedge clk);
    @(negedge clk);
    chk("drain_idle_busy", busy, 0);

    // Reset while holding a result with three commands queued.
    n_cmd = 4; k = 0; acc = 1'b0;
    out_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      drive_step();
      @(negedge clk);
    end
    chk("pre_rst_hold", out_valid, 1);
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_alu_s", alu_s, 4'b1111);
    chk("mid_rst_out_res", out_res, 0);
    out_ready = 1'b1;
    stale = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (out_valid || busy) stale++;
    end
    chk("mid_rst_no_stale", stale, 0);

`ifdef ALU_ISSUE_CNT_EN
    begin
      int n_hs, n_acc, cyc;
      do_reset();
      chk("cnt_reset", done_cnt, 0);
      in_a = 4'd1; in_b = 4'd1; in_op = 4'd0; out_ready = 1'b1;
      n_hs = 0; n_acc = 0; cyc = 0; acc = 1'b0;
      while (n_hs < 257 && cyc < 2000) begin
        if (acc) n_acc++;
        in_valid = (n_acc < 257);
        acc = in_valid && in_ready;
        if (out_valid) n_hs++;
        @(negedge clk);
        cyc++;
      end
      in_valid = 1'b0;
      chk("cnt_handshakes", n_hs, 257);
      chk("cnt_wrap", done_cnt, 1);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter: DEPTH, 4, command FIFO depth in entries; power of two, at least 2.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: in_valid  input  1  upstream command present.
REQ-005 Port: in_ready  output  1  block can accept a command.
REQ-006 Port: in_a  input  4  operand A.
REQ-007 Port: in_b  input  4  operand B.
REQ-008 Port: in_op  input  4  ALU select code.
REQ-009 Port: alu_a  output  4  registered operand A to the ALU.
REQ-010 Port: alu_b  output  4  registered operand B to the ALU.
REQ-011 Port: alu_s  output  4  registered select to the ALU.
REQ-012 Port: alu_res  input  5  combinational ALU result.
REQ-013 Port: out_valid  output  1  result available downstream.
REQ-014 Port: out_ready  input  1  downstream accepts result.
REQ-015 Port: out_res  output  5  captured ALU result.
REQ-016 Port: out_op  output  4  original in_op of that result.
REQ-017 Port: busy  output  1  high when state is not IDLE or FIFO is non-empty.

Function
REQ-018 A command {in_op,in_a,in_b} SHALL be written to the FIFO tail on a clock edge where in_valid and in_ready are both high.
REQ-019 in_ready SHALL equal (FIFO count < DEPTH), with no combinational path from out_ready.
REQ-020 FIFO read and write pointers SHALL wrap modulo DEPTH; a push and a pop on the same edge SHALL leave count unchanged.
REQ-021 The FSM SHALL have three states: IDLE, ISSUE, HOLD.
REQ-022 IDLE: if the FIFO is non-empty, on the next edge pop the head, load alu_a/alu_b/alu_s, and go to ISSUE; otherwise stay in IDLE.
REQ-023 ISSUE: on the next edge capture alu_res into out_res, the popped op into out_op, set out_valid=1, and go to HOLD.
REQ-024 HOLD: out_valid, out_res and out_op SHALL stay stable until an edge where out_ready=1.
REQ-025 On that edge, out_valid SHALL clear. If the FIFO is non-empty, the FSM SHALL pop and load the next command and go to ISSUE (back-to-back); otherwise it SHALL go to IDLE.
REQ-026 Latency: a command accepted into an empty FIFO while in IDLE SHALL raise out_valid exactly 2 edges after the acceptance edge.
REQ-027 Select code 4'b1000 (no defined ALU operation) SHALL be driven on alu_s as 4'b1111, so out_res is 0; out_op SHALL still report 4'b1000.
REQ-028 alu_a, alu_b and alu_s SHALL change only on load edges.
REQ-029 Results SHALL leave in command acceptance order; none SHALL be dropped or duplicated.

Reset
REQ-030 While rst=1 at an edge, the block SHALL do all of the following:
- state set to IDLE;
- FIFO emptied (pointers and count 0);
- out_valid=0, out_res=0, out_op=0;
- alu_a=0, alu_b=0, alu_s=4'b1111;
- in_ready=1, busy=0 after that edge.
REQ-031 Reset asserted mid-operation (in ISSUE or HOLD) SHALL discard the in-flight result and all queued commands.

Configuration
REQ-032 Macro ALU_ISSUE_CNT_EN defined: the block SHALL add output port done_cnt (8 bits).
- done_cnt increments on each out_valid&&out_ready edge.
- It wraps from 255 to 0.
- Reset sets it to 0.
REQ-033 Macro ALU_ISSUE_CNT_EN undefined: port done_cnt and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-034 Scenario: a=3, b=5, op=0000, out_ready=1 -> out_valid high 2 edges after acceptance, out_res=8, out_op=0000.
REQ-035 Scenario: a=2, b=3, op=0001 -> out_res=5'b11111; then a=4'hF, b=1, op=0000 -> out_res=5'b10000.
REQ-036 Scenario: out_ready=0, in_valid held high with 6 distinct commands ->
- the 1st command reaches HOLD;
- the next 4 fill the FIFO;
- in_ready goes low and the 6th waits;
- raising out_ready drains all 6 in order, one per 2 edges.
REQ-037 Scenario: op=1000, a=7, b=7 -> alu_s=1111, out_res=0, out_op=1000.
REQ-038 Scenario: rst pulsed while in HOLD with 3 commands queued -> next edge shows out_valid=0, in_ready=1, busy=0, alu_s=1111, and no stale results afterward.
REQ-039 Scenario, with ALU_ISSUE_CNT_EN defined: 257 completed handshakes -> done_cnt=1.
